vend_input_arbiter: RTL and testbench
=====================================

Name: vend_input_arbiter

Overview:
- Front-end controller for the vending FSM.
- Conditions the four raw user inputs (nickel, dime, jolt, buzzWater): synchronise, debounce and edge-detect each one.
- Latches each press as a pending request, then issues requests to the vending FSM one at a time as registered one-cycle pulses.
- Holds off while the FSM reports a dispense or return in progress, so simultaneous or bouncing presses cannot corrupt its state.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before the debounced level changes (range 1..255).
- GAP_CYCLES, 2: minimum idle cycles inserted after every issued pulse (range 0..15).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- nickel_raw  input  1  raw nickel button/switch, asynchronous
- dime_raw  input  1  raw dime button/switch, asynchronous
- jolt_raw  input  1  raw jolt selection, asynchronous
- buzzWater_raw  input  1  raw buzzWater selection, asynchronous
- busy  input  1  high while the vending FSM drives any dispense or return output
- nickel  output  1  one-cycle request pulse to the vending FSM
- dime  output  1  one-cycle request pulse
- jolt  output  1  one-cycle request pulse
- buzzWater  output  1  one-cycle request pulse
- pending  output  4  latched requests {buzzWater, jolt, dime, nickel}
- overrun  output  1  sticky flag: a press was lost

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-high.
- On reset:
  - all four pulse outputs = 0; pending = 4'b0000; overrun = 0.
  - synchronisers, debounced levels and debounce counters = 0.
  - FSM = IDLE; gap counter = 0.
  - Reset mid-operation discards all pending requests and any pulse in flight.
- Per input channel:
  - 2-flop synchroniser produces s.
  - Debounce counter increments while s != deb and clears when s == deb.
  - When the counter reaches DEBOUNCE_CYCLES, deb <= s and the counter clears.
  - Rising edge of deb (deb=1, deb_d=0) is a press event. Falling edges are ignored.
- Pending bit per channel:
  - Set on a press event.
  - Cleared in the cycle the channel is issued.
  - Press event in the same cycle as that channel's clear: bit stays set (new request kept), no overrun.
  - Press event while the bit is already set and not being cleared: overrun <= 1. overrun stays 1 until reset.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if busy == 0 and pending != 0, latch the grant and go to ISSUE. Otherwise stay in IDLE.
  - Grant priority (fixed): dime > nickel > jolt > buzzWater. Coins are served before selections.
  - ISSUE (1 cycle): the granted output = 1, all other pulse outputs = 0; clear the granted pending bit.
    - GAP_CYCLES == 0: go to IDLE.
    - Otherwise: load the gap counter and go to GAP.
  - GAP: count down; go to IDLE after GAP_CYCLES cycles. busy is ignored in GAP.
  - busy is sampled only in IDLE. busy rising during ISSUE/GAP has no effect on the current pulse.
- Pulse outputs are registered:
  - never more than one high in a cycle;
  - each high for exactly one cycle per issued request.
- Latency, raw rise to pulse, channel idle and busy=0 throughout: 2 (sync) + DEBOUNCE_CYCLES + 1 (pending) + 1 (issue) clock edges. Default = 8 cycles.
- Throughput: at most one pulse per (1 + GAP_CYCLES) cycles when busy stays 0.
- Bounce shorter than DEBOUNCE_CYCLES stable samples produces no press event.
- pending reflects register state directly; no extra latency.

Test Plan:
- Reset: assert reset mid-GAP with pending=4'b0110 -> all pulse outputs 0, pending=0, overrun=0 immediately (asynchronous), no pulses for 10 cycles after release.
- Single press: nickel_raw 0->1 held 20 cycles, defaults, busy=0 -> nickel high exactly 1 cycle, 8 cycles after the sampling edge; pending[0] sets then clears; nothing else fires.
- Bounce: dime_raw toggles every 2 cycles for 12 cycles then holds high -> exactly one dime pulse. A 3-cycle glitch alone -> no pulse.
- Simultaneous: all four raw inputs rise together -> pulses in order dime, nickel, jolt, buzzWater, each 3 cycles apart (GAP_CYCLES=2); pending goes 1111 -> 1101 -> 1100 -> 1000 -> 0000.
- Busy holdoff: jolt pending while busy=1 for 15 cycles -> no jolt pulse; jolt pulse 1 cycle after busy falls (IDLE detects, then ISSUE).
- Overrun: with busy=1, press buzzWater, release, press again -> overrun=1 and stays 1; after busy falls exactly one buzzWater pulse is issued.

Source files
------------

// File: rtl/vend_input_arbiter.sv
// vend_input_arbiter
// Front end for the vending FSM. Each of the four raw inputs (nickel, dime,
// jolt, buzzWater) is synchronised, debounced and edge-detected. Every press
// is latched as a pending request. Requests are then issued to the vending
// FSM one at a time, as registered one-cycle pulses, with a minimum idle
// spacing between pulses. Requests are held back while the FSM reports a
// dispense or return in progress.
//
// Channel index order everywhere: 0 = nickel, 1 = dime, 2 = jolt,
// 3 = buzzWater. This matches the bit order of the pending output.

module vend_input_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4,  // stable samples before the level flips (1..255)
  parameter int GAP_CYCLES      = 2   // idle cycles after every pulse (0..15)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nickel_raw,
  input  logic       dime_raw,
  input  logic       jolt_raw,
  input  logic       buzzWater_raw,
  input  logic       busy,
  output logic       nickel,
  output logic       dime,
  output logic       jolt,
  output logic       buzzWater,
  output logic [3:0] pending,
  output logic       overrun
);

  // The debounce counter fires when it has already counted DEBOUNCE_CYCLES-1
  // differing samples and sees one more.
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Pulse spacing. The IDLE cycle in which the next grant is decided is
  // itself one of the idle cycles after a pulse. The GAP state therefore
  // only has to cover the remaining GAP_CYCLES-1 cycles. With GAP_CYCLES of
  // 0 or 1, ISSUE returns straight to IDLE.
  localparam int         GAP_LOAD_INT = (GAP_CYCLES >= 2) ? (GAP_CYCLES - 2) : 0;
  localparam logic [3:0] GAP_LOAD     = 4'(GAP_LOAD_INT);
  localparam bit         USE_GAP      = (GAP_CYCLES >= 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  logic [3:0] raw_vec;
  logic [3:0] press;

  assign raw_vec = {buzzWater_raw, jolt_raw, dime_raw, nickel_raw};

  // ---------------------------------------------------------------------
  // Per-channel conditioning: 2-flop synchroniser, debounce, rising edge
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      logic       sync1_q;
      logic       sync2_q;
      logic       deb_q;
      logic       deb_dly_q;
      logic       deb_d;
      logic [7:0] cnt_q;
      logic [7:0] cnt_d;

      // Debounce next state: count differing samples; flip the level once
      // enough consecutive samples disagree with it.
      always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync2_q == deb_q) begin
          cnt_d = 8'd0;
        end else if (cnt_q == DEB_LAST) begin
          deb_d = sync2_q;
          cnt_d = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // Synchroniser, debounced level and its one-cycle delayed copy.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_q   <= 1'b0;
          sync2_q   <= 1'b0;
          deb_q     <= 1'b0;
          deb_dly_q <= 1'b0;
          cnt_q     <= 8'd0;
        end else begin
          sync1_q   <= raw_vec[gi];
          sync2_q   <= sync1_q;
          deb_q     <= deb_d;
          deb_dly_q <= deb_q;
          cnt_q     <= cnt_d;
        end
      end

      // Only the rising edge of the debounced level is a press.
      assign press[gi] = deb_q & ~deb_dly_q;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Pending requests and overrun flag
  // ---------------------------------------------------------------------
  logic [3:0] pending_q;
  logic [3:0] pending_d;
  logic       overrun_q;
  logic       overrun_d;
  logic [3:0] pulse_q;
  logic [3:0] pulse_d;

  // pulse_q is non-zero only during ISSUE, and then holds the latched grant.
  // It therefore doubles as the clear mask for the granted pending bit.
  // A press that coincides with its own clear re-arms the bit and is not
  // counted as a loss.
  always_comb begin
    pending_d = (pending_q & ~pulse_q) | press;
    overrun_d = overrun_q | (|(press & pending_q & ~pulse_q));
  end

  // Pending bits and the sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 4'b0000;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic [3:0] gap_q;
  logic [3:0] gap_d;
  logic [3:0] grant;

  // Fixed priority: coins before selections, dime before nickel.
  always_comb begin
    grant = 4'b0000;
    if (pending_q[1]) begin
      grant = 4'b0010;
    end else if (pending_q[0]) begin
      grant = 4'b0001;
    end else if (pending_q[2]) begin
      grant = 4'b0100;
    end else if (pending_q[3]) begin
      grant = 4'b1000;
    end
  end

  // Next state and next pulse vector. busy is looked at only in IDLE.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pulse_d = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (!busy && (pending_q != 4'b0000)) begin
          pulse_d = grant;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (USE_GAP) begin
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, gap counter and the registered request pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gap_q   <= 4'd0;
      pulse_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
    end
  end

  assign nickel    = pulse_q[0];
  assign dime      = pulse_q[1];
  assign jolt      = pulse_q[2];
  assign buzzWater = pulse_q[3];
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_vend_input_arbiter.sv
// Self-checking bench for vend_input_arbiter. A behavioural model predicts
// pulses, pending and overrun every cycle. Directed scenarios add explicit
// checks for latency, bounce, ordering, busy holdoff, overrun and reset.
// A randomized phase follows the directed scenarios.

module tb_vend_input_arbiter;

  localparam int DEB     = 4;
  localparam int GAP     = 2;
  localparam int LAT     = 2 + DEB + 1 + 1;
  localparam int SPACING = ((GAP + 1) > 2) ? (GAP + 1) : 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] raw_v = 4'b0000;
  logic       busy = 1'b0;
  logic       nickel, dime, jolt, buzzWater;
  logic [3:0] pending;
  logic       overrun;
  logic [3:0] pv;

  assign pv = {buzzWater, jolt, dime, nickel};

  vend_input_arbiter #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .nickel_raw   (raw_v[0]),
    .dime_raw     (raw_v[1]),
    .jolt_raw     (raw_v[2]),
    .buzzWater_raw(raw_v[3]),
    .busy         (busy),
    .nickel       (nickel),
    .dime         (dime),
    .jolt         (jolt),
    .buzzWater    (buzzWater),
    .pending      (pending),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int obs_cnt[4];
  int base[4];
  int ev_edge[$];
  logic [3:0] ev_vec[$];

  // Model state: raw delay line, sample windows, debounced levels, requests.
  logic [3:0]     m_d1, m_d2, m_deb, m_rose, m_pend, m_pulse;
  logic           m_ovr;
  logic [DEB-1:0] m_hist[4];
  int             m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pick(input logic [3:0] p);
    if (p[1]) return 4'b0010;
    if (p[0]) return 4'b0001;
    if (p[2]) return 4'b0100;
    if (p[3]) return 4'b1000;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_deb = '0; m_rose = '0;
    m_pend = '0; m_pulse = '0; m_ovr = 1'b0; m_last = -1000;
    for (int c = 0; c < 4; c++) m_hist[c] = '0;
  endtask

  // One clock edge of the model, computed from pre-edge values.
  task automatic model_step();
    logic [3:0] nxt;
    logic [3:0] press;
    nxt = 4'b0000;
    // A new pulse is allowed when requests exist, busy is low, and the
    // minimum spacing since the last pulse has elapsed.
    if (m_pend != 4'b0000 && !busy && (edge_n - m_last) >= SPACING) begin
      nxt    = pick(m_pend);
      m_last = edge_n;
    end
    press = m_rose;
    if ((press & m_pend & ~m_pulse) != 4'b0000) m_ovr = 1'b1;
    m_pend = (m_pend & ~m_pulse) | press;
    // Debounce: the level flips once the last DEB synchronised samples all
    // disagree with it.
    for (int c = 0; c < 4; c++) begin
      m_hist[c] = {m_hist[c][DEB-2:0], m_d2[c]};
      m_rose[c] = 1'b0;
      if (m_hist[c] == {DEB{~m_deb[c]}}) begin
        m_deb[c]  = ~m_deb[c];
        m_rose[c] = m_deb[c];
      end
    end
    m_d2    = m_d1;
    m_d1    = raw_v;
    m_pulse = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (!reset) model_step();
    #1;
    chk("pulses", 32'(pv), 32'(m_pulse));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("onehot0", 32'($onehot0(pv)), 32'd1);
    for (int c = 0; c < 4; c++) if (pv[c]) obs_cnt[c]++;
    if (pv != 4'b0000) begin
      ev_edge.push_back(edge_n);
      ev_vec.push_back(pv);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic snap();
    for (int c = 0; c < 4; c++) base[c] = obs_cnt[c];
  endtask

  initial begin
    int hold[4];
    for (int c = 0; c < 4; c++) begin obs_cnt[c] = 0; hold[c] = 0; end
    model_reset();

    // Reset state
    #2;
    chk("rst_pulses", 32'(pv), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    ticks(2);
    reset = 1'b0;
    ticks(3);

    // Single nickel press: pulse exactly LAT edges after the sampling edge
    snap();
    raw_v[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == LAT - 1) chk("lat_before", 32'(nickel), 32'd0);
      if (k == LAT)     chk("lat_pulse", 32'(nickel), 32'd1);
      if (k == LAT + 1) chk("lat_after", 32'(nickel), 32'd0);
    end
    chk("single_nickel_cnt", 32'(obs_cnt[0] - base[0]), 32'd1);
    chk("single_others_cnt", 32'(obs_cnt[1] + obs_cnt[2] + obs_cnt[3]
                                 - base[1] - base[2] - base[3]), 32'd0);
    raw_v[0] = 1'b0;
    ticks(12);

    // Bouncing dime, then held high: exactly one pulse
    snap();
    for (int k = 0; k < 12; k++) begin
      raw_v[1] = ((k / 2) % 2 == 0);
      tick();
    end
    raw_v[1] = 1'b1;
    ticks(20);
    raw_v[1] = 1'b0;
    ticks(12);
    chk("bounce_dime_cnt", 32'(obs_cnt[1] - base[1]), 32'd1);

    // 3-cycle glitch alone: no pulse
    snap();
    raw_v[0] = 1'b1;
    ticks(3);
    raw_v[0] = 1'b0;
    ticks(15);
    chk("glitch_nickel_cnt", 32'(obs_cnt[0] - base[0]), 32'd0);

    // All four at once: dime, nickel, jolt, buzzWater, SPACING apart
    ev_edge.delete();
    ev_vec.delete();
    raw_v = 4'b1111;
    ticks(25);
    raw_v = 4'b0000;
    chk("sim_count", 32'(ev_vec.size()), 32'd4);
    if (ev_vec.size() == 4) begin
      chk("sim_first", 32'(ev_vec[0]), 32'h2);
      chk("sim_second", 32'(ev_vec[1]), 32'h1);
      chk("sim_third", 32'(ev_vec[2]), 32'h4);
      chk("sim_fourth", 32'(ev_vec[3]), 32'h8);
      for (int i = 1; i < 4; i++)
        chk("sim_spacing", 32'(ev_edge[i] - ev_edge[i-1]), 32'(SPACING));
    end
    ticks(12);

    // Busy holdoff on jolt
    snap();
    busy = 1'b1;
    raw_v[2] = 1'b1;
    ticks(20);
    chk("busy_no_jolt", 32'(obs_cnt[2] - base[2]), 32'd0);
    chk("busy_jolt_pending", 32'(pending[2]), 32'd1);
    busy = 1'b0;
    tick();
    chk("busy_release_jolt", 32'(jolt), 32'd1);
    raw_v[2] = 1'b0;
    ticks(12);

    // Overrun on buzzWater while busy
    snap();
    busy = 1'b1;
    raw_v[3] = 1'b1; ticks(8);
    raw_v[3] = 1'b0; ticks(8);
    raw_v[3] = 1'b1; ticks(8);
    chk("overrun_set", 32'(overrun), 32'd1);
    busy = 1'b0;
    ticks(10);
    chk("overrun_buzz_cnt", 32'(obs_cnt[3] - base[3]), 32'd1);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    raw_v[3] = 1'b0;
    ticks(12);

    // Asynchronous reset in GAP with pending = 0110
    raw_v[0] = 1'b1;
    tick();
    raw_v[1] = 1'b1;
    raw_v[2] = 1'b1;
    ticks(LAT);
    chk("pre_reset_pending", 32'(pending), 32'h6);
    raw_v = 4'b0000;
    reset = 1'b1;
    #1;
    chk("async_rst_pulses", 32'(pv), 32'd0);
    chk("async_rst_pending", 32'(pending), 32'd0);
    chk("async_rst_overrun", 32'(overrun), 32'd0);
    model_reset();
    ticks(2);
    reset = 1'b0;
    snap();
    ticks(10);
    chk("post_reset_quiet", 32'(obs_cnt[0] + obs_cnt[1] + obs_cnt[2] + obs_cnt[3]
                                - base[0] - base[1] - base[2] - base[3]), 32'd0);

    // Randomized phase against the model
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          raw_v[c] = 1'($urandom_range(0, 1));
          hold[c]  = int'($urandom_range(1, 14));
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 9) == 0) busy = ~busy;
      tick();
    end
    raw_v = 4'b0000;
    busy  = 1'b0;
    ticks(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
